matmul_engine: RTL and testbench

MATMUL_ENGINE -- requirements
Module: matmul_engine

---
 rtl/matmul_engine.sv | 172 +++++++++++++++++
 tb/tb_matmul_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_engine.sv
// Square signed matrix multiplier over external synchronous RAMs: C = A*B or C = C + A*B.
// One MAC per cycle, column-major storage, results written in linear C address order.
module matmul_engine #(
  parameter int N     = 8,
  parameter int DW    = 8,
  parameter int CNT_W = 16,
  localparam int LOG_N = $clog2(N),
  localparam int AW    = 2 * LOG_N,
  localparam int ACC_W = 2 * DW + LOG_N
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  output logic [AW-1:0]           a_addr,
  input  logic signed [DW-1:0]    a_rdata,
  output logic [AW-1:0]           b_addr,
  input  logic signed [DW-1:0]    b_rdata,
  output logic [AW-1:0]           c_raddr,
  input  logic signed [ACC_W-1:0] c_rdata,
  output logic                    c_we,
  output logic [AW-1:0]           c_waddr,
  output logic signed [ACC_W-1:0] c_wdata,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        clock_count
);

  localparam int IW = 3 * LOG_N;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

  state_t               state_r, state_n_s;
  logic [IW-1:0]        idx_r, idx_n_s;
  logic                 accept_s, run_n_s, issue_s;
  logic                 mode_r, busy_r, done_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [AW-1:0]        a_addr_r, b_addr_r, c_raddr_r, c_waddr_r;
  logic                 vld_p_r, k0_p_r, c_we_r;
  logic [LOG_N-1:0]     k_s, k_n_s, r_n_s, c_n_s;
  logic [AW-1:0]        e_s, e_n_s;
  logic [2*DW-1:0]      prod_s;
  logic [ACC_W-1:0]     prod_ext_s, acc_in_s, sum_s, acc_r;

  // idx = {col, row, k}: issue order is k fastest, then linear element address
  assign k_s     = idx_r[LOG_N-1:0];
  assign e_s     = idx_r[IW-1:LOG_N];
  assign k_n_s   = idx_n_s[LOG_N-1:0];
  assign r_n_s   = idx_n_s[2*LOG_N-1:LOG_N];
  assign c_n_s   = idx_n_s[IW-1:2*LOG_N];
  assign e_n_s   = idx_n_s[IW-1:LOG_N];
  assign issue_s = (state_r == RUN);
  assign run_n_s = (state_n_s == RUN);

  // Next-state and issue-index logic
  always_comb begin
    state_n_s = state_r;
    idx_n_s   = idx_r;
    accept_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n_s = RUN;
          idx_n_s   = {IW{1'b0}};
          accept_s  = 1'b1;
        end else begin
          state_n_s = IDLE;
        end
      end
      RUN: begin
        idx_n_s = idx_r + {{(IW-1){1'b0}}, 1'b1};
        if (idx_r == {IW{1'b1}}) begin
          state_n_s = FINISH;
        end else begin
          state_n_s = RUN;
        end
      end
      FINISH:  state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_n_s;
  end

  // Run control: index, mode latch, busy/done flags and saturating cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_r  <= {IW{1'b0}};
      mode_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      idx_r  <= idx_n_s;
      busy_r <= (state_n_s == RUN) || (state_n_s == FINISH);
      if (accept_s) begin
        mode_r <= mode;
        done_r <= 1'b0;
        cnt_r  <= {CNT_W{1'b0}};
      end else begin
        if (state_r == FINISH) done_r <= 1'b1;
        if (busy_r && (cnt_r != {CNT_W{1'b1}})) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Read addresses registered from the next index so they line up with the RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_addr_r  <= {AW{1'b0}};
      b_addr_r  <= {AW{1'b0}};
      c_raddr_r <= {AW{1'b0}};
    end else if (run_n_s) begin
      a_addr_r  <= {k_n_s, r_n_s};
      b_addr_r  <= {c_n_s, k_n_s};
      c_raddr_r <= e_n_s;
    end else begin
      a_addr_r  <= {AW{1'b0}};
      b_addr_r  <= {AW{1'b0}};
      c_raddr_r <= {AW{1'b0}};
    end
  end

  // Low 2*DW bits of the sign-extended product equal the signed product
  assign prod_s     = {{DW{a_rdata[DW-1]}}, a_rdata} * {{DW{b_rdata[DW-1]}}, b_rdata};
  assign prod_ext_s = {{LOG_N{prod_s[2*DW-1]}}, prod_s};

  // Accumulator input: restart on k = 0 from zero or the old C value
  always_comb begin
    acc_in_s = acc_r;
    if (k0_p_r) begin
      if (mode_r) acc_in_s = c_rdata;
      else        acc_in_s = {ACC_W{1'b0}};
    end else begin
      acc_in_s = acc_r;
    end
  end

  assign sum_s = acc_in_s + prod_ext_s;

  // Data-return stage: MAC and write strobe one cycle behind issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p_r   <= 1'b0;
      k0_p_r    <= 1'b0;
      c_we_r    <= 1'b0;
      c_waddr_r <= {AW{1'b0}};
      acc_r     <= {ACC_W{1'b0}};
    end else begin
      vld_p_r   <= issue_s;
      k0_p_r    <= issue_s && (k_s == {LOG_N{1'b0}});
      c_we_r    <= issue_s && (k_s == {LOG_N{1'b1}});
      c_waddr_r <= issue_s ? e_s : {AW{1'b0}};
      if (vld_p_r) acc_r <= sum_s;
    end
  end

  assign a_addr      = a_addr_r;
  assign b_addr      = b_addr_r;
  assign c_raddr     = c_raddr_r;
  assign c_we        = c_we_r;
  assign c_waddr     = c_waddr_r;
  assign c_wdata     = c_we_r ? sum_s : {ACC_W{1'b0}};
  assign busy        = busy_r;
  assign done        = done_r;
  assign clock_count = cnt_r;

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine at N=8/DW=8 and N=4/DW=4 with RAM models and a write scoreboard.
module tb_matmul_engine;

  typedef struct {int addr; int data;} wr_t;

  logic clk = 1'b0;
  logic reset, start8, mode8, start4, mode4;
  int   tests = 0;
  int   fails = 0;

  logic [5:0]         a_addr8, b_addr8, c_raddr8, c_waddr8;
  logic signed [7:0]  a_rd8, b_rd8;
  logic signed [18:0] c_rd8, c_wdata8;
  logic               c_we8, busy8, done8;
  logic [15:0]        cc8;
  logic signed [7:0]  a8 [64];
  logic signed [7:0]  b8 [64];
  logic signed [18:0] c8 [64];

  logic [3:0]         a_addr4, b_addr4, c_raddr4, c_waddr4;
  logic signed [3:0]  a_rd4, b_rd4;
  logic signed [9:0]  c_rd4, c_wdata4;
  logic               c_we4, busy4, done4;
  logic [15:0]        cc4;
  logic signed [3:0]  a4 [16];
  logic signed [3:0]  b4 [16];
  logic signed [9:0]  c4 [16];

  wr_t q8[$];
  wr_t q4[$];

  always #5 clk = ~clk;

  matmul_engine u8 (
    .clk(clk), .reset(reset), .start(start8), .mode(mode8),
    .a_addr(a_addr8), .a_rdata(a_rd8), .b_addr(b_addr8), .b_rdata(b_rd8),
    .c_raddr(c_raddr8), .c_rdata(c_rd8), .c_we(c_we8), .c_waddr(c_waddr8),
    .c_wdata(c_wdata8), .busy(busy8), .done(done8), .clock_count(cc8));

  matmul_engine #(.N(4), .DW(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .mode(mode4),
    .a_addr(a_addr4), .a_rdata(a_rd4), .b_addr(b_addr4), .b_rdata(b_rd4),
    .c_raddr(c_raddr4), .c_rdata(c_rd4), .c_we(c_we4), .c_waddr(c_waddr4),
    .c_wdata(c_wdata4), .busy(busy4), .done(done4), .clock_count(cc4));

  // Synchronous RAM models, one cycle read latency
  always @(posedge clk) begin
    a_rd8 <= a8[a_addr8];
    b_rd8 <= b8[b_addr8];
    c_rd8 <= c8[c_raddr8];
    if (c_we8) c8[c_waddr8] <= c_wdata8;
    a_rd4 <= a4[a_addr4];
    b_rd4 <= b4[b_addr4];
    c_rd4 <= c4[c_raddr4];
    if (c_we4) c4[c_waddr4] <= c_wdata4;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboards: each write must match the next expected (address, data) in order
  always @(negedge clk) begin
    wr_t w;
    if (c_we8 === 1'b1) begin
      if (q8.size() == 0) chk("c8_extra_write", 64'sd1, 64'sd0);
      else begin
        w = q8.pop_front();
        chk("c8_waddr", {58'd0, c_waddr8}, w.addr);
        chk("c8_wdata", c_wdata8, w.data);
      end
    end
    if (c_we4 === 1'b1) begin
      if (q4.size() == 0) chk("c4_extra_write", 64'sd1, 64'sd0);
      else begin
        w = q4.pop_front();
        chk("c4_waddr", {60'd0, c_waddr4}, w.addr);
        chk("c4_wdata", c_wdata4, w.data);
      end
    end
  end

  task automatic push8_const(input int v);
    for (int e = 0; e < 64; e++) q8.push_back('{e, v});
  endtask

  task automatic push8_ref(input bit m);
    for (int e = 0; e < 64; e++) begin
      int s;
      logic signed [18:0] t;
      s = m ? int'(c8[e]) : 0;
      for (int k = 0; k < 8; k++) s += int'(a8[(e % 8) + 8 * k]) * int'(b8[k + 8 * (e / 8)]);
      t = s[18:0];
      q8.push_back('{e, int'(t)});
    end
  endtask

  task automatic run8(input bit m, input bit glitch, input string tag);
    int  cnt;
    bit  fin;
    cnt = 1;
    fin = 1'b0;
    @(negedge clk); start8 = 1'b1; mode8 = m;
    @(negedge clk); start8 = 1'b0;
    chk({tag, "_done_clr"}, done8, 1'b0);
    chk({tag, "_busy_set"}, busy8, 1'b1);
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(negedge clk);
      if (busy8) cnt++;
      start8 = glitch && (cnt == 10 || cnt == 512);
      if (!busy8 && done8) fin = 1'b1;
    end
    start8 = 1'b0;
    chk({tag, "_finished"}, fin, 1'b1);
    chk({tag, "_busy_cycles"}, cnt, 513);
    chk({tag, "_clock_count"}, {48'd0, cc8}, 513);
    chk({tag, "_pending"}, q8.size(), 0);
    chk({tag, "_a_addr_idle"}, {58'd0, a_addr8}, 0);
  endtask

  initial begin
    int cnt;
    bit fin;
    reset = 1'b1; start8 = 1'b0; mode8 = 1'b0; start4 = 1'b0; mode4 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      a8[i] = (i % 9 == 0) ? 8'sd1 : 8'sd0;
      b8[i] = 8'($urandom_range(0, 255));
      c8[i] = 19'sd0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_c_we", c_we8, 1'b0);
    chk("rst_count", {48'd0, cc8}, 0);
    chk("rst_a_addr", {58'd0, a_addr8}, 0);
    chk("rst_c_wdata", c_wdata8, 0);
    reset = 1'b0;

    // Identity times B must reproduce B
    for (int e = 0; e < 64; e++) q8.push_back('{e, int'(b8[e])});
    run8(1'b0, 1'b0, "ident");

    // Extreme operands
    for (int i = 0; i < 64; i++) begin a8[i] = -8'sd128; b8[i] = -8'sd128; end
    push8_const(131072);
    run8(1'b0, 1'b0, "neg_neg");
    for (int i = 0; i < 64; i++) b8[i] = 8'sd127;
    push8_const(-130048);
    run8(1'b0, 1'b0, "neg_pos");

    // Accumulate mode
    for (int i = 0; i < 64; i++) begin a8[i] = 8'sd1; b8[i] = 8'sd1; c8[i] = 19'sd5; end
    push8_const(13);
    run8(1'b1, 1'b0, "acc1");
    push8_const(21);
    run8(1'b1, 1'b0, "acc2");

    // Start pulses mid-run and in the last RUN cycle are ignored
    push8_const(8);
    run8(1'b0, 1'b1, "glitch");
    repeat (4) @(negedge clk);
    chk("glitch_no_rerun", busy8, 1'b0);
    chk("glitch_done_hold", done8, 1'b1);
    push8_const(8);
    run8(1'b0, 1'b0, "restart_from_done");

    // Asynchronous reset mid-run
    for (int i = 0; i < 64; i++) begin
      a8[i] = (i % 9 == 0) ? 8'sd1 : 8'sd0;
      b8[i] = 8'($urandom_range(0, 255));
    end
    push8_ref(1'b0);
    @(negedge clk); start8 = 1'b1; mode8 = 1'b0;
    @(negedge clk); start8 = 1'b0;
    cnt = 1;
    for (int i = 0; i < 200 && cnt < 100; i++) begin
      @(negedge clk);
      if (busy8) cnt++;
    end
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    chk("abort_c_we", c_we8, 1'b0);
    chk("abort_count", {48'd0, cc8}, 0);
    q8.delete();
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("abort_idle_busy", busy8, 1'b0);
    push8_ref(1'b0);
    run8(1'b0, 1'b0, "after_abort");

    // Small configuration against a reference model
    for (int i = 0; i < 16; i++) begin
      a4[i] = 4'($urandom_range(0, 15));
      b4[i] = 4'($urandom_range(0, 15));
    end
    for (int e = 0; e < 16; e++) begin
      int s;
      logic signed [9:0] t;
      s = 0;
      for (int k = 0; k < 4; k++) s += int'(a4[(e % 4) + 4 * k]) * int'(b4[k + 4 * (e / 4)]);
      t = s[9:0];
      q4.push_back('{e, int'(t)});
    end
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    cnt = 1;
    fin = 1'b0;
    for (int i = 0; i < 500 && !fin; i++) begin
      @(negedge clk);
      if (busy4) cnt++;
      if (!busy4 && done4) fin = 1'b1;
    end
    chk("n4_finished", fin, 1'b1);
    chk("n4_busy_cycles", cnt, 65);
    chk("n4_clock_count", {48'd0, cc4}, 65);
    chk("n4_pending", q4.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
